// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI arbiter: registered active-low grants, a dead cycle between
// owners, hidden arbitration during a transaction, and a timeout on unused grants.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int TIMEOUT     = 16,
  parameter int PARK_EN     = 1,
  parameter int PARK_MASTER = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic                         frame,
  input  logic                         irdy,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_valid,
  output logic                         bus_idle,
  output logic                         timeout_evt,
  output logic [1:0]                   dbg_state
);
  localparam int            OW      = $clog2(N_MASTERS);
  localparam logic [OW-1:0] PARK_OW = OW'(PARK_MASTER);

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_GRANT  = 2'd2,
    ST_BUSY   = 2'd3
  } state_t;

  state_t                r_state;
  logic [N_MASTERS-1:0]  r_gnt;
  logic [OW-1:0]         r_owner;
  logic                  r_owner_valid;
  logic                  r_bus_idle;
  logic                  r_timeout_evt;
  logic [OW-1:0]         r_last;
  logic [OW-1:0]         r_target;
  logic [7:0]            r_cnt;
  logic                  r_handoff;

  logic                  w_idle;
  logic                  w_any;
  logic                  w_found;
  logic [OW-1:0]         w_next;

  function automatic logic [N_MASTERS-1:0] grant_vec(input logic [OW-1:0] idx);
    grant_vec      = '1;
    grant_vec[idx] = 1'b0;
  endfunction

  assign w_idle = frame & irdy;
  assign w_any  = ~&req;

  // Scan last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    w_next  = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (!w_found && !req[OW'((int'(r_last) + k) % N_MASTERS)]) begin
        w_found = 1'b1;
        w_next  = OW'((int'(r_last) + k) % N_MASTERS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_PARK;
      r_gnt         <= '1;
      r_owner       <= PARK_OW;
      r_owner_valid <= 1'b0;
      r_bus_idle    <= 1'b1;
      r_timeout_evt <= 1'b0;
      r_last        <= PARK_OW;
      r_target      <= PARK_OW;
      r_cnt         <= 8'd0;
      r_handoff     <= 1'b0;
    end else begin
      r_bus_idle    <= w_idle;
      r_timeout_evt <= 1'b0;
      case (r_state)
        ST_PARK: begin
          if (w_found) begin
            if (w_next == r_owner && r_owner_valid) begin
              r_last  <= w_next;
              r_cnt   <= 8'd0;
              r_state <= ST_GRANT;
            end else begin
              r_gnt         <= '1;
              r_owner_valid <= 1'b0;
              r_target      <= w_next;
              r_handoff     <= 1'b0;
              r_state       <= ST_SWITCH;
            end
          end else if (PARK_EN != 0 && (!r_owner_valid || r_owner == PARK_OW)) begin
            r_gnt         <= grant_vec(PARK_OW);
            r_owner       <= PARK_OW;
            r_owner_valid <= 1'b1;
          end else begin
            // A non-park owner must pass through an all-high cycle before parking.
            r_gnt         <= '1;
            r_owner_valid <= 1'b0;
          end
        end
        ST_SWITCH: begin
          r_gnt         <= grant_vec(r_target);
          r_owner       <= r_target;
          r_owner_valid <= 1'b1;
          r_last        <= r_target;
          r_cnt         <= 8'd0;
          r_state       <= r_handoff ? ST_BUSY : ST_GRANT;
        end
        ST_GRANT: begin
          if (!frame) begin
            r_state <= ST_BUSY;
          end else if (req[r_owner]) begin
            r_gnt         <= '1;
            r_owner_valid <= 1'b0;
            r_state       <= ST_PARK;
          end else if (w_idle) begin
            if (r_cnt == 8'(TIMEOUT - 1)) begin
              r_gnt         <= '1;
              r_owner_valid <= 1'b0;
              r_timeout_evt <= 1'b1;
              r_last        <= r_owner;
              r_state       <= ST_PARK;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_BUSY: begin
          // Hidden arbitration: hand over while the current transaction finishes.
          if (req[r_owner] && w_any) begin
            r_gnt         <= '1;
            r_owner_valid <= 1'b0;
            r_target      <= w_next;
            r_handoff     <= 1'b1;
            r_state       <= ST_SWITCH;
          end else if (w_idle) begin
            r_handoff <= 1'b0;
            r_cnt     <= 8'd0;
            r_state   <= r_handoff ? ST_GRANT : ST_PARK;
          end
        end
        default: r_state <= ST_PARK;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;
  assign bus_idle    = r_bus_idle;
  assign timeout_evt = r_timeout_evt;
  assign dbg_state   = r_state;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (N_MASTERS=4, TIMEOUT=16, parked on master 0).
module tb_pci_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       frame;
  logic       irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       owner_valid;
  logic       bus_idle;
  logic       timeout_evt;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] S_PARK = 2'd0, S_SWITCH = 2'd1, S_GRANT = 2'd2, S_BUSY = 2'd3;

  pci_bus_arbiter #(.N_MASTERS(4), .TIMEOUT(16), .PARK_EN(1), .PARK_MASTER(0)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .irdy(irdy),
    .gnt(gnt), .owner(owner), .owner_valid(owner_valid), .bus_idle(bus_idle),
    .timeout_evt(timeout_evt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; frame = 1'b1; irdy = 1'b1;
    tick();
    n_vec++;
    if ({gnt, owner, owner_valid, bus_idle, timeout_evt, dbg_state} !== {4'b1111, 2'd0, 1'b0, 1'b1, 1'b0, S_PARK}) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b owner=%0d ov=%b idle=%b tmo=%b st=%0d expected 1111/0/0/1/0/0",
               gnt, owner, owner_valid, bus_idle, timeout_evt, dbg_state);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({gnt, owner_valid, bus_idle} !== {4'b1110, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL park_after_reset: gnt=%b ov=%b idle=%b expected 1110/1/1", gnt, owner_valid, bus_idle);
    end
  endtask

  task automatic test_grant_switch();
    req = 4'b0101;
    tick();
    n_vec++;
    if ({gnt, owner_valid, dbg_state} !== {4'b1111, 1'b0, S_SWITCH}) begin
      n_err++;
      $display("FAIL rr_dead_cycle: gnt=%b ov=%b st=%0d expected 1111/0/1", gnt, owner_valid, dbg_state);
    end
    tick();
    n_vec++;
    if ({gnt, owner, dbg_state} !== {4'b1101, 2'd1, S_GRANT}) begin
      n_err++;
      $display("FAIL rr_grant1: gnt=%b owner=%0d st=%0d expected 1101/1/2", gnt, owner, dbg_state);
    end
    frame = 1'b0; irdy = 1'b0;
    tick();
    n_vec++;
    if ({gnt, dbg_state, bus_idle} !== {4'b1101, S_BUSY, 1'b0}) begin
      n_err++;
      $display("FAIL m1_busy: gnt=%b st=%0d idle=%b expected 1101/3/0", gnt, dbg_state, bus_idle);
    end
    frame = 1'b1;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b1101, S_BUSY}) begin
      n_err++;
      $display("FAIL m1_last_data: gnt=%b st=%0d expected 1101/3", gnt, dbg_state);
    end
    irdy = 1'b1;
    tick();
    n_vec++;
    if ({gnt, dbg_state, bus_idle} !== {4'b1101, S_PARK, 1'b1}) begin
      n_err++;
      $display("FAIL m1_idle_park: gnt=%b st=%0d idle=%b expected 1101/0/1", gnt, dbg_state, bus_idle);
    end
    req = 4'b0111;
    tick();
    n_vec++;
    if (gnt !== 4'b1111) begin
      n_err++;
      $display("FAIL m1_to_m3_dead: gnt=%b expected 1111", gnt);
    end
    tick();
    n_vec++;
    if ({gnt, owner} !== {4'b0111, 2'd3}) begin
      n_err++;
      $display("FAIL m3_grant: gnt=%b owner=%0d expected 0111/3", gnt, owner);
    end
    req = 4'b1111;
    tick();
    n_vec++;
    if ({gnt, owner_valid, dbg_state} !== {4'b1111, 1'b0, S_PARK}) begin
      n_err++;
      $display("FAIL m3_release: gnt=%b ov=%b st=%0d expected 1111/0/0", gnt, owner_valid, dbg_state);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b1110) begin
      n_err++;
      $display("FAIL repark: gnt=%b expected 1110", gnt);
    end
  endtask

  task automatic test_timeout();
    req = 4'b1011;
    tick();
    tick();
    n_vec++;
    if ({gnt, owner} !== {4'b1011, 2'd2}) begin
      n_err++;
      $display("FAIL m2_grant: gnt=%b owner=%0d expected 1011/2", gnt, owner);
    end
    req = 4'b0011;
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_vec++;
      if ({gnt, timeout_evt} !== {4'b1011, 1'b0}) begin
        n_err++;
        $display("FAIL m2_wait_%0d: gnt=%b tmo=%b expected 1011/0", i, gnt, timeout_evt);
      end
    end
    tick();
    n_vec++;
    if ({gnt, timeout_evt, dbg_state} !== {4'b1111, 1'b1, S_PARK}) begin
      n_err++;
      $display("FAIL m2_timeout: gnt=%b tmo=%b st=%0d expected 1111/1/0", gnt, timeout_evt, dbg_state);
    end
    tick();
    n_vec++;
    if ({gnt, timeout_evt} !== {4'b1111, 1'b0}) begin
      n_err++;
      $display("FAIL tmo_pulse_width: gnt=%b tmo=%b expected 1111/0", gnt, timeout_evt);
    end
    tick();
    n_vec++;
    if ({gnt, owner} !== {4'b0111, 2'd3}) begin
      n_err++;
      $display("FAIL after_tmo_grant: gnt=%b owner=%0d expected 0111/3", gnt, owner);
    end
    req = 4'b1111;
    tick();
    tick();
    n_vec++;
    if (gnt !== 4'b1110) begin
      n_err++;
      $display("FAIL tmo_repark: gnt=%b expected 1110", gnt);
    end
  endtask

  task automatic test_hidden_arb();
    req = 4'b1110;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b1110, S_GRANT}) begin
      n_err++;
      $display("FAIL park_no_dead: gnt=%b st=%0d expected 1110/2", gnt, dbg_state);
    end
    frame = 1'b0; irdy = 1'b0;
    tick();
    req = 4'b0110;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b1110, S_BUSY}) begin
      n_err++;
      $display("FAIL m0_busy_hold: gnt=%b st=%0d expected 1110/3", gnt, dbg_state);
    end
    req = 4'b0111;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b1111, S_SWITCH}) begin
      n_err++;
      $display("FAIL hidden_dead: gnt=%b st=%0d expected 1111/1", gnt, dbg_state);
    end
    tick();
    n_vec++;
    if ({gnt, owner, dbg_state} !== {4'b0111, 2'd3, S_BUSY}) begin
      n_err++;
      $display("FAIL hidden_grant: gnt=%b owner=%0d st=%0d expected 0111/3/3", gnt, owner, dbg_state);
    end
    tick();
    frame = 1'b1;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b0111, S_BUSY}) begin
      n_err++;
      $display("FAIL hidden_wait_idle: gnt=%b st=%0d expected 0111/3", gnt, dbg_state);
    end
    irdy = 1'b1;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b0111, S_GRANT}) begin
      n_err++;
      $display("FAIL hidden_to_grant: gnt=%b st=%0d expected 0111/2", gnt, dbg_state);
    end
    for (int i = 0; i < 15; i++) tick();
    n_vec++;
    if ({gnt, dbg_state, timeout_evt} !== {4'b0111, S_GRANT, 1'b0}) begin
      n_err++;
      $display("FAIL m3_wait15: gnt=%b st=%0d tmo=%b expected 0111/2/0", gnt, dbg_state, timeout_evt);
    end
    frame = 1'b0;
    tick();
    n_vec++;
    if ({gnt, dbg_state, timeout_evt} !== {4'b0111, S_BUSY, 1'b0}) begin
      n_err++;
      $display("FAIL frame_beats_tmo: gnt=%b st=%0d tmo=%b expected 0111/3/0", gnt, dbg_state, timeout_evt);
    end
    frame = 1'b1;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b0111, S_PARK}) begin
      n_err++;
      $display("FAIL m3_done_park: gnt=%b st=%0d expected 0111/0", gnt, dbg_state);
    end
    req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b1111) begin
      n_err++;
      $display("FAIL m3_to_park_dead: gnt=%b expected 1111", gnt);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b1110) begin
      n_err++;
      $display("FAIL m3_to_park: gnt=%b expected 1110", gnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_q[$];
    logic [3:0] prev_gnt;
    int         cycles;
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    prev_gnt = gnt;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      tick();
      cycles++;
      n_vec++;
      if ($countones(~gnt) > 1) begin
        n_err++;
        $display("FAIL one_hot_gnt: gnt=%b expected at most one low bit", gnt);
      end
      n_vec++;
      if (prev_gnt !== 4'b1111 && gnt !== 4'b1111 && gnt !== prev_gnt) begin
        n_err++;
        $display("FAIL no_dead_cycle: gnt=%b after %b expected 1111 between owners", gnt, prev_gnt);
      end
      if (prev_gnt === 4'b1111 && gnt !== 4'b1111) begin
        n_vec++;
        if (owner !== exp_q[0] || gnt[exp_q[0]] !== 1'b0) begin
          n_err++;
          $display("FAIL rr_order: owner=%0d gnt=%b expected owner %0d", owner, gnt, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      prev_gnt = gnt;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_budget: %0d grants missing after %0d cycles, expected 0", exp_q.size(), cycles);
    end
  endtask

  task automatic test_reset_busy();
    frame = 1'b0; irdy = 1'b0;
    tick();
    n_vec++;
    if ({gnt, dbg_state} !== {4'b1101, S_BUSY}) begin
      n_err++;
      $display("FAIL pre_rst_busy: gnt=%b st=%0d expected 1101/3", gnt, dbg_state);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({gnt, owner, owner_valid, bus_idle, dbg_state} !== {4'b1111, 2'd0, 1'b0, 1'b1, S_PARK}) begin
      n_err++;
      $display("FAIL rst_in_busy: gnt=%b owner=%0d ov=%b idle=%b st=%0d expected 1111/0/0/1/0",
               gnt, owner, owner_valid, bus_idle, dbg_state);
    end
    rst = 1'b0; frame = 1'b1; irdy = 1'b1; req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b1110) begin
      n_err++;
      $display("FAIL post_rst_park: gnt=%b expected 1110", gnt);
    end
  endtask

  initial begin
    test_reset();
    test_grant_switch();
    test_timeout();
    test_hidden_arb();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
